wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first:
  clk       in   1   single clock; all state on rising edge
  rst_n     in   1   asynchronous, active-low reset
  req       in   4   write-port request, bit i = requester i
  lock      in   4   requester i asks to keep the port after this grant
  wreg      in   12  destination register index; requester i at [3i+2:3i]
  wdata     in   64  write data; requester i at [16i+15:16i]
  gnt       out  4   one-hot grant, combinational, same cycle as req
  wr_en     out  8   registered one-hot register-file write enable
  wr_data   out  16  registered write data
  wr_src    out  2   registered index of the requester that was written
  busy      out  1   high while in LOCK state
REQ-002 SHALL have no parameters; requester count is 4, register count is 8, data width is 16.

Function
REQ-003 SHALL assert at most one gnt bit per cycle, and gnt[i] only when req[i]=1.
REQ-004 SHALL hold req until gnt is seen; requester treats req&gnt in a cycle as accepted; dropping req before grant is legal.
REQ-005 SHALL use a round-robin pointer ptr[1:0]: search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); first requesting index wins.
REQ-006 SHALL set ptr <= (granted index + 1) mod 4 on every grant; ptr unchanged when no grant.
REQ-007 SHALL, on the edge after gnt[i], load wr_en <= one-hot of wreg[3i+2:3i] (000->01h ... 111->80h), wr_data <= wdata_i, wr_src <= i; write latency exactly 1 cycle.
REQ-008 SHALL drive wr_en = 00h for a cycle following a cycle with no grant; wr_data and wr_src hold their last value.
REQ-009 SHALL implement state machine {IDLE, LOCK} with a 2-bit owner register.
REQ-010 IDLE: grant per REQ-005; if granted i has lock[i]=1 -> LOCK, owner <= i.
REQ-011 LOCK: only owner may be granted (gnt[owner]=req[owner]); all other requests blocked regardless of ptr.
REQ-012 LOCK -> IDLE when owner granted with lock[owner]=0, or when req[owner]=0 (abandon, no grant that cycle).
REQ-013 SHALL drive busy=1 exactly when state=LOCK.
REQ-014 Boundary: req=0 -> gnt=0, next wr_en=00h; req=Fh continuously -> grants rotate 0,1,2,3 from ptr=0; lock asserted without req ignored.

Reset
REQ-015 SHALL, while rst_n=0, asynchronously force state=IDLE, ptr=0, owner=0, wr_en=00h, wr_data=0000h, wr_src=0; gnt then follows REQ-005 with ptr=0.
REQ-016 SHALL abandon any lock on reset mid-operation; the first grant after release follows round-robin from ptr=0.

Configuration
REQ-017 SHALL honour macro WB_PORT_ARBITER_RR_EN: defined -> round-robin per REQ-005/006; undefined -> fixed priority, requester 0 highest, requester 3 lowest, ptr held at 0; LOCK behaviour identical in both builds.

Verification
REQ-018 Reset: rst_n=0 mid-LOCK with owner=2 -> busy=0, wr_en=00h, wr_src=0 immediately, without a clock edge.
REQ-019 Round robin (RR_EN defined): req=Fh for 5 cycles from reset -> gnt sequence 1h,2h,4h,8h,1h; wr_src 0,1,2,3,0 one cycle later.
REQ-020 Decode/latency: req=4h, wreg[8:6]=101b, wdata[47:32]=BEEFh -> gnt=4h same cycle; next cycle wr_en=20h, wr_data=BEEFh, wr_src=2; cycle after, wr_en=00h.
REQ-021 Lock: req=3h, lock=1h for 3 cycles, then lock=0h -> gnt=1h four cycles with busy=1 for cycles 2-4; requester 1 granted on cycle 5.
REQ-022 Abandon: in LOCK owner=3, req drops to 1h -> no grant that cycle, busy=0 next cycle, then gnt=1h.
REQ-023 Fixed priority (RR_EN undefined): req=Ah for 3 cycles -> gnt=2h every cycle; requester 3 starved.

Source files
------------

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// wb_port_arbiter: 4-requester register-file write-port arbiter with lock and 1-cycle registered write.
// Macro WB_PORT_ARBITER_RR_EN: defined -> round-robin; undefined -> fixed priority (requester 0 highest).
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    input  logic [11:0] wreg,
    input  logic [63:0] wdata,
    output logic [3:0]  gnt,
    output logic [7:0]  wr_en,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_src,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_ptr;
    logic [1:0] r_owner;
    logic [1:0] w_owner_nxt;
    logic [1:0] w_idx;
    logic [1:0] w_cand;
    logic       w_vld;
    logic [2:0] w_reg_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_idx       = 2'd0;
        w_vld       = 1'b0;
        w_cand      = 2'd0;
        if (r_state == S_IDLE) begin
            // Walk the search order backwards so the candidate closest to ptr wins.
            for (int k = 3; k >= 0; k--) begin
                w_cand = r_ptr + 2'(k);
                if (req[w_cand]) begin
                    w_idx = w_cand;
                    w_vld = 1'b1;
                end
            end
            if (w_vld && lock[w_idx]) begin
                w_state_nxt = S_LOCK;
                w_owner_nxt = w_idx;
            end
        end else begin
            if (req[r_owner]) begin
                w_idx = r_owner;
                w_vld = 1'b1;
                if (!lock[r_owner]) begin
                    w_state_nxt = S_IDLE;
                end
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    assign gnt       = w_vld ? (4'b0001 << w_idx) : 4'b0000;
    assign busy      = (r_state == S_LOCK);
    assign w_reg_sel = wreg[3*w_idx +: 3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 2'd0;
            r_ptr   <= 2'd0;
            wr_en   <= 8'h00;
            wr_data <= 16'h0000;
            wr_src  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
`ifdef WB_PORT_ARBITER_RR_EN
            if (w_vld) begin
                r_ptr <= w_idx + 2'd1;
            end
`else
            r_ptr <= 2'd0;
`endif
            if (w_vld) begin
                wr_en   <= 8'h01 << w_reg_sel;
                wr_data <= wdata[16*w_idx +: 16];
                wr_src  <= w_idx;
            end else begin
                wr_en   <= 8'h00;
            end
        end
    end

endmodule
`default_nettype wire
